// File: rtl/fpu_issue_fifo_pkg.sv
// Shared FPU definitions: opcode width and encodings, issue FIFO depth,
// pointer/count widths and a pointer-increment helper.
`ifndef FPU_ISSUE_FIFO_PKG_SV
`define FPU_ISSUE_FIFO_PKG_SV

package fpu_issue_fifo_pkg;

    localparam int FPU_OP_W   = 4;
    localparam int FPU_DEPTH  = 4;
    localparam int FPU_PTR_W  = 2;
    localparam int FPU_CNT_W  = 3;
    localparam int FPU_RD_W   = 5;
    localparam int FPU_DATA_W = 32;

    typedef enum logic [FPU_OP_W-1:0] {
        FOP_ADD  = 4'd0,
        FOP_SUB  = 4'd1,
        FOP_MUL  = 4'd2,
        FOP_DIV  = 4'd3,
        FOP_SQRT = 4'd4,
        FOP_MIN  = 4'd5,
        FOP_MAX  = 4'd6,
        FOP_CVT  = 4'd7,
        FOP_CMP  = 4'd8
    } fpu_op_e;

    // Pointers are exactly FPU_PTR_W bits wide, so the wrap from 3 to 0 is free.
    function automatic logic [FPU_PTR_W-1:0] ptr_inc(input logic [FPU_PTR_W-1:0] p);
        return p + FPU_PTR_W'(1);
    endfunction

endpackage

`endif

// File: rtl/mux2to1by32.sv
// 2:1 multiplexer on 32-bit words.
module mux2to1by32 (
    input  logic [31:0] d0,
    input  logic [31:0] d1,
    input  logic        sel,
    output logic [31:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux4to1by32.sv
// 4:1 multiplexer on 32-bit words.
module mux4to1by32 (
    input  logic [31:0] d0,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic [31:0] d3,
    input  logic [1:0]  sel,
    output logic [31:0] y
);

    // Select one of four words.
    always_comb begin
        y = d0;
        case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/fpu_issue_fifo.sv
// Four-entry issue FIFO between FP operand selection and FPU execute.
// Optional macro FPU_ISSUE_BYPASS_EN: when the FIFO is empty an offered
// operation is presented at the output in the same cycle and, if taken,
// never stored.
module fpu_issue_fifo
    import fpu_issue_fifo_pkg::*;
#(
    parameter int OP_W  = FPU_OP_W,
    parameter int DEPTH = FPU_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_op,
    input  logic [4:0]      in_rd,
    input  logic [31:0]     in_a,
    input  logic [31:0]     in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] out_op,
    output logic [4:0]      out_rd,
    output logic [31:0]     out_a,
    output logic [31:0]     out_b,
    output logic [2:0]      count
);

    logic [FPU_PTR_W-1:0] wr_ptr;
    logic [FPU_PTR_W-1:0] rd_ptr;
    logic [FPU_CNT_W-1:0] cnt_q;

    logic [OP_W-1:0] op_mem [DEPTH];
    logic [4:0]      rd_mem [DEPTH];
    logic [31:0]     a_mem  [DEPTH];
    logic [31:0]     b_mem  [DEPTH];

    logic        empty;
    logic        full;
    logic        bypass;
    logic        push;
    logic        store;
    logic        pop;
    logic [31:0] head_a;
    logic [31:0] head_b;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == FPU_CNT_W'(DEPTH));
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    // A bypassed operation that is taken the same cycle is never written.
    assign store    = push && !(bypass && out_ready);
    assign pop      = !empty && out_ready;
    assign count    = cnt_q;

    mux4to1by32 u_head_a (
        .d0  (a_mem[0]),
        .d1  (a_mem[1]),
        .d2  (a_mem[2]),
        .d3  (a_mem[3]),
        .sel (rd_ptr),
        .y   (head_a)
    );

    mux4to1by32 u_head_b (
        .d0  (b_mem[0]),
        .d1  (b_mem[1]),
        .d2  (b_mem[2]),
        .d3  (b_mem[3]),
        .sel (rd_ptr),
        .y   (head_b)
    );

`ifdef FPU_ISSUE_BYPASS_EN
    assign bypass    = empty && in_valid && !flush;
    assign out_valid = !empty || bypass;
    assign out_op    = bypass ? in_op : op_mem[rd_ptr];
    assign out_rd    = bypass ? in_rd : rd_mem[rd_ptr];

    mux2to1by32 u_byp_a (
        .d0  (head_a),
        .d1  (in_a),
        .sel (bypass),
        .y   (out_a)
    );

    mux2to1by32 u_byp_b (
        .d0  (head_b),
        .d1  (in_b),
        .sel (bypass),
        .y   (out_b)
    );
`else
    assign bypass    = 1'b0;
    assign out_valid = !empty;
    assign out_op    = op_mem[rd_ptr];
    assign out_rd    = rd_mem[rd_ptr];

    // Operand buses read as zero while nothing is presented.
    mux2to1by32 u_hold_a (
        .d0  (32'h0),
        .d1  (head_a),
        .sel (out_valid),
        .y   (out_a)
    );

    mux2to1by32 u_hold_b (
        .d0  (32'h0),
        .d1  (head_b),
        .sel (out_valid),
        .y   (out_b)
    );
`endif

    // Pointer and occupancy update; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (store) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)   rd_ptr <= ptr_inc(rd_ptr);
            if (store && !pop)      cnt_q <= cnt_q + FPU_CNT_W'(1);
            else if (!store && pop) cnt_q <= cnt_q - FPU_CNT_W'(1);
        end
    end

    // Entry storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (!reset && !flush && store) begin
            op_mem[wr_ptr] <= in_op;
            rd_mem[wr_ptr] <= in_rd;
            a_mem[wr_ptr]  <= in_a;
            b_mem[wr_ptr]  <= in_b;
        end
    end

endmodule

// File: tb/tb_fpu_issue_fifo.sv
// Scoreboard bench for fpu_issue_fifo: a queue model tracks contents,
// the monitor checks flags, count and popped data every cycle.
module tb_fpu_issue_fifo;

    localparam int OP_W = 4;
`ifdef FPU_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] in_op;
    logic [4:0]      in_rd;
    logic [31:0]     in_a;
    logic [31:0]     in_b;
    logic            out_valid;
    logic            out_ready;
    logic [OP_W-1:0] out_op;
    logic [4:0]      out_rd;
    logic [31:0]     out_a;
    logic [31:0]     out_b;
    logic [2:0]      count;

    always #5 clk = ~clk;

    fpu_issue_fifo #(.OP_W(OP_W), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_rd    (out_rd),
        .out_a     (out_a),
        .out_b     (out_b),
        .count     (count)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    ent_t        sb[$];
    ent_t        e;
    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    bit          mon_on = 1'b0;
    bit          exp_v;
    bit          exp_r;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Monitor: mid-cycle, compare against the queue model, then apply the
    // upcoming edge's accept/consume to the model (push before pop so a
    // same-cycle bypass consumes the incoming operation).
    always @(negedge clk) begin
        if (mon_on) begin
            exp_r = (sb.size() != 4);
            exp_v = (sb.size() != 0) || (BYP && in_valid && !flush);
            chk("count", 32'(count), 32'(sb.size()));
            chk("in_ready", 32'(in_ready), 32'(exp_r));
            chk("out_valid", 32'(out_valid), 32'(exp_v));
            if (reset || flush) begin
                sb.delete();
            end else begin
                if (in_valid && exp_r) begin
                    e.op = in_op; e.rd = in_rd; e.a = in_a; e.b = in_b;
                    sb.push_back(e);
                end
                if (exp_v && out_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("out_op", 32'(out_op), 32'(e.op));
                    chk("out_rd", 32'(out_rd), 32'(e.rd));
                    chk("out_a", out_a, e.a);
                    chk("out_b", out_b, e.b);
                end
            end
        end
    end

    task automatic step(input bit v, input bit r, input bit f, input bit rs,
                        input logic [3:0] op, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b);
        in_valid = v; out_ready = r; flush = f; reset = rs;
        in_op = op; in_rd = rd; in_a = a; in_b = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit r);
        step(1'b0, r, 1'b0, 1'b0, 4'd0, 5'd0, 32'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_rd = '0; in_a = '0; in_b = '0;
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 5'd0, 32'h0, 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);

        // Single push, visible next cycle
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 5'd5, 32'h3F800000, 32'h40000000);
        chk("push1_valid", 32'(out_valid), 32'd1);
        chk("push1_a", out_a, 32'h3F800000);
        chk("push1_b", out_b, 32'h40000000);
        chk("push1_count", 32'(count), 32'd1);
        idle(1'b1);

        // Fill, overfill attempt, drain in order
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 4'(i), 5'(i + 8), 32'hA0000000 + 32'(i), 32'hB0000000 + 32'(i));
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 5'd31, 32'hDEADBEEF, 32'hDEADBEEF);
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("drained_count", 32'(count), 32'd0);

        // Full with simultaneous offer and take; pointers wrap
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 4'(i), 5'(i), 32'hC0000000 + 32'(i), 32'(i));
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 5'd9, 32'hC1000000, 32'h9);
        chk("fullpop_count", 32'(count), 32'd3);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd10, 5'd10, 32'hC2000000, 32'hA);
        chk("pushpop_count", 32'(count), 32'd3);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 4'(i), 5'(i + 20), 32'hC3000000 + 32'(i), 32'(i));
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Flush wins over push and pop
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 5'd1, 32'hD0000001, 32'h1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 5'd2, 32'hD0000002, 32'h2);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 5'd3, 32'hD0000003, 32'h3);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        idle(1'b0);

        // Reset mid-operation
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 4'(i), 5'(i), 32'hE0000000 + 32'(i), 32'(i));
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 5'd0, 32'h0, 32'h0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 5'd4, 32'h12345678, 32'h87654321);
        chk("midrst_head", out_a, 32'h12345678);
        idle(1'b1);
        idle(1'b0);

        // Empty FIFO, offer with out_ready: bypass vs stored
        in_valid = 1'b1; out_ready = 1'b1; in_op = 4'd2; in_rd = 5'd7;
        in_a = 32'h40400000; in_b = 32'h3F000000;
        #1;
        chk("byp_out_valid", 32'(out_valid), 32'(BYP));
`ifdef FPU_ISSUE_BYPASS_EN
        chk("byp_out_a", out_a, 32'h40400000);
`endif
        @(posedge clk);
        #1;
        chk("byp_count", 32'(count), BYP ? 32'd0 : 32'd1);
        idle(1'b1);
        idle(1'b0);

        // Randomized traffic
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2,
                 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                 $urandom, $urandom);
        for (int i = 0; i < 6; i++) idle(1'b1);
        chk("final_count", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
